mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Owns the single byte-wide RAM port and shares it between two requesters:
//  the ICache (4-byte fetch reads) and the load/store buffer (1/2/4-byte reads and writes).
//  Grants one port at a time and sequences the transfer byte by byte (little-endian).
//  Returns an assembled word with a one-cycle done pulse. Sits between the caches/LSB and the RAM/IO pins.
// PARAMETERS
//  ADDR_W   32  address width; the RAM uses bits 17:0
//  IO_HI    2'b11  value of addr[17:16] that selects the IO region
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous, active-high reset
//  rdy            in   1   pause: when low, no state or output register changes
//  clr            in   1   flush from flow controller; aborts reads
//  if_req         in   1   ICache read request, level, held until if_done
//  if_addr        in   32  fetch address
//  if_done        out  1   one-cycle pulse, if_data valid
//  if_data        out  32  fetched word
//  ls_req         in   1   LSB request, level, held until ls_done
//  ls_wr          in   1   1 = write, 0 = read
//  ls_size        in   2   0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes (3 is illegal, treated as 4)
//  ls_addr        in   32  byte address; misaligned addresses are legal
//  ls_wdata       in   32  write data; low N bytes are used
//  ls_done        out  1   one-cycle pulse; ls_rdata valid on reads
//  ls_rdata       out  32  read data, zero-extended above N bytes
//  mem_din        in   8   RAM read byte, returned one cycle after mem_a
//  mem_dout       out  8   RAM write byte
//  mem_a          out  32  RAM byte address
//  mem_wr         out  1   write strobe; output is mem_wr_reg & rdy
//  io_buffer_full in   1   IO sink cannot accept a write
// BEHAVIOUR
//  States: IDLE, READ, WRITE, IO_WAIT; byte counter cnt[2:0]; latched addr, size N, wdata, port id.
//  Reset: state IDLE, cnt 0, every output 0, last_grant = LS, so IF wins the first tie.
//  Grant (IDLE only): a single requester wins; if both request, the port not granted last wins.
//  Requests are not sampled on the edge immediately after a done pulse.
//  Read, acceptance edge E0: mem_a = addr.
//   At E_k (k = 1..N-1): mem_a = addr + k and byte k-1 is captured from mem_din.
//   At E_N: byte N-1 is captured, done and data are asserted, and the state returns to IDLE.
//   Latency is N cycles from acceptance. An IF read always has N = 4.
//  Write, E0: mem_a = addr, mem_dout = wdata[7:0], mem_wr = 1.
//   At E_k: mem_a = addr + k, mem_dout = byte k.
//   At E_N: mem_wr = 0, ls_done = 1, state IDLE.
//  IO write: if addr[17:16] == IO_HI and io_buffer_full at acceptance, enter IO_WAIT with mem_wr = 0.
//   The first byte is issued on the first edge where io_buffer_full is low.
//   io_buffer_full is checked before every byte of an IO write.
//  Address arithmetic: addr + k is a 32-bit add and wraps modulo 2^32.
//  clr high at an edge:
//   READ aborts, goes to IDLE, and no done is pulsed.
//   IDLE grants nothing that cycle.
//   WRITE and IO_WAIT are unaffected; committed stores always complete.
//  clr and a final read byte on the same edge: clr wins, no done is pulsed.
//  rdy low: state, cnt, and all registers are frozen; mem_wr reads 0; sequencing resumes unchanged.
//  rst mid-transfer: immediate return to IDLE with outputs 0; a partial write is not rolled back.
//  The done outputs are held high for exactly one cycle; data outputs hold their value until the next done.
// STRUCTURE
//  Add to constants.v: state encodings, size encodings (SZ_B/SZ_H/SZ_W), and an IO-region predicate macro.
//  One sub-module, mem_byte_seq. It holds cnt, the address increment, byte shift-in/shift-out, and the done signal.
//  mem_arbiter keeps the grant logic, the last_grant bit, the IO/clr handling, and the output muxing.
// TESTING
//  1. IF read 0x100, RAM 0x100..0x103 = 13,00,00,00 -> if_done 4 cycles after accept, if_data 0x00000013.
//  2. Both ports request in the same cycle, then both request again -> IF granted first, then LS.
//     Check that no byte from one transfer lands in the other's data.
//  3. LS write size 1, addr 0x30000, data 0x41, io_buffer_full high for 3 cycles:
//     -> mem_wr stays 0 for 3 cycles, then one write of 0x41 at 0x30000, then ls_done.
//  4. LS read size 2 at 0x1FF, RAM = AB,CD -> ls_rdata 0x0000CDAB after 2 cycles.
//     Also: size 4 at 0xFFFFFFFE wraps to 0x0.
//  5. clr asserted at cycle 2 of an IF read -> no if_done, return to IDLE.
//     A pending LS write is granted afterwards and completes.
//  6. rdy low for 5 cycles mid-write -> mem_wr 0 throughout and mem_a held.
//     Afterwards the remaining bytes are written exactly once; rst mid-read gives all outputs 0 the next cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types, encodings and helpers for the byte-wide RAM port arbiter.
package mem_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_WRITE   = 2'd2,
        ST_IO_WAIT = 2'd3
    } state_t;

    // LSB transfer size encodings
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Port identifiers used for grant tracking
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LS = 1'b1;

    // Byte count for a size code; the illegal code 3 behaves as a word
    function automatic logic [CNT_W-1:0] size_to_n(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // True when address bits 17:16 select the IO region
    function automatic logic in_io_region(input logic [1:0] hi_bits, input logic [1:0] io_hi);
        return hi_bits == io_hi;
    endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer: byte counter, address increment, write shift-out, read shift-in.
module mem_byte_seq
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              load,
    input  logic              load_first,
    input  logic              adv,
    input  logic              cap,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [CNT_W-1:0]  ld_n,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [ADDR_W-1:0] addr_c,
    output logic [BYTE_W-1:0] byte_c,
    output logic [DATA_W-1:0] word_c,
    output logic              last_c
);

    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  n;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] wsh;
    logic [DATA_W-1:0] rdata;

    // Transfer context and progress; load with first byte issued leaves cnt at 1
    always_ff @(posedge clk) begin
        if (rst) begin
            base  <= '0;
            n     <= '0;
            cnt   <= '0;
            wsh   <= '0;
            rdata <= '0;
        end else if (rdy) begin
            if (load) begin
                base  <= ld_addr;
                n     <= ld_n;
                rdata <= '0;
                if (load_first) begin
                    cnt <= 3'd1;
                    wsh <= ld_wdata >> BYTE_W;
                end else begin
                    cnt <= 3'd0;
                    wsh <= ld_wdata;
                end
            end else begin
                if (cap) begin
                    rdata <= word_c;
                end
                if (adv) begin
                    cnt <= cnt + 3'd1;
                    wsh <= wsh >> BYTE_W;
                end
            end
        end
    end

    // Next byte address wraps modulo 2^ADDR_W; done when all bytes issued
    always_comb begin
        addr_c = base + ADDR_W'(cnt);
        byte_c = wsh[BYTE_W-1:0];
        last_c = (cnt == n);
    end

    // Merge the byte on mem_din into the slot of the previously addressed byte
    always_comb begin
        word_c = rdata;
        case (2'(cnt - 3'd1))
            2'd0:    word_c[7:0]   = mem_din;
            2'd1:    word_c[15:8]  = mem_din;
            2'd2:    word_c[23:16] = mem_din;
            default: word_c[31:24] = mem_din;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-wide RAM port between ICache fetches and LSB loads/stores.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [1:0]  IO_HI  = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [BYTE_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state;
    logic              last_grant;
    logic              port;
    logic              cur_io;
    logic              mem_wr_reg;

    logic              take_c;
    logic              pick_ls_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic              sel_wr_c;
    logic              sel_io_c;
    logic [CNT_W-1:0]  sel_n_c;
    logic              sel_io_wait_c;
    logic              adv_c;
    logic              cap_c;

    logic [ADDR_W-1:0] seq_addr_c;
    logic [BYTE_W-1:0] seq_byte_c;
    logic [DATA_W-1:0] seq_word_c;
    logic              seq_last_c;

    assign mem_wr = mem_wr_reg & rdy;

    // Grant choice and sequencer strobes for the current cycle
    always_comb begin
        take_c    = 1'b0;
        pick_ls_c = 1'b0;
        adv_c     = 1'b0;
        cap_c     = 1'b0;
        if (state == ST_IDLE && !clr && !if_done && !ls_done) begin
            if (if_req && ls_req) begin
                take_c    = 1'b1;
                pick_ls_c = (last_grant == PORT_IF);
            end else if (if_req) begin
                take_c = 1'b1;
            end else if (ls_req) begin
                take_c    = 1'b1;
                pick_ls_c = 1'b1;
            end
        end
        sel_addr_c    = pick_ls_c ? ls_addr : if_addr;
        sel_wr_c      = pick_ls_c & ls_wr;
        sel_n_c       = pick_ls_c ? size_to_n(ls_size) : 3'd4;
        sel_io_c      = in_io_region(sel_addr_c[17:16], IO_HI);
        sel_io_wait_c = sel_wr_c & sel_io_c & io_buffer_full;
        case (state)
            ST_READ: begin
                if (!clr) begin
                    cap_c = 1'b1;
                    adv_c = !seq_last_c;
                end
            end
            ST_WRITE: begin
                if (!seq_last_c && !(cur_io && io_buffer_full)) begin
                    adv_c = 1'b1;
                end
            end
            ST_IO_WAIT: begin
                if (!io_buffer_full) begin
                    adv_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    mem_byte_seq #(
        .ADDR_W(ADDR_W)
    ) u_seq (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .load      (take_c),
        .load_first(take_c & !sel_io_wait_c),
        .adv       (adv_c),
        .cap       (cap_c),
        .ld_addr   (sel_addr_c),
        .ld_n      (sel_n_c),
        .ld_wdata  (ls_wdata),
        .mem_din   (mem_din),
        .addr_c    (seq_addr_c),
        .byte_c    (seq_byte_c),
        .word_c    (seq_word_c),
        .last_c    (seq_last_c)
    );

    // Arbiter state machine with registered RAM and requester outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= PORT_LS;
            port       <= PORT_IF;
            cur_io     <= 1'b0;
            mem_wr_reg <= 1'b0;
            mem_a      <= '0;
            mem_dout   <= '0;
            if_done    <= 1'b0;
            if_data    <= '0;
            ls_done    <= 1'b0;
            ls_rdata   <= '0;
        end else if (rdy) begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take_c) begin
                        last_grant <= pick_ls_c;
                        port       <= pick_ls_c;
                        cur_io     <= sel_io_c;
                        if (!sel_wr_c) begin
                            state      <= ST_READ;
                            mem_a      <= sel_addr_c;
                            mem_wr_reg <= 1'b0;
                        end else if (sel_io_wait_c) begin
                            state      <= ST_IO_WAIT;
                            mem_wr_reg <= 1'b0;
                        end else begin
                            state      <= ST_WRITE;
                            mem_a      <= sel_addr_c;
                            mem_dout   <= ls_wdata[7:0];
                            mem_wr_reg <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (clr) begin
                        state <= ST_IDLE;
                    end else if (seq_last_c) begin
                        state <= ST_IDLE;
                        if (port == PORT_LS) begin
                            ls_done  <= 1'b1;
                            ls_rdata <= seq_word_c;
                        end else begin
                            if_done <= 1'b1;
                            if_data <= seq_word_c;
                        end
                    end else begin
                        mem_a <= seq_addr_c;
                    end
                end
                ST_WRITE: begin
                    if (seq_last_c) begin
                        mem_wr_reg <= 1'b0;
                        ls_done    <= 1'b1;
                        state      <= ST_IDLE;
                    end else if (cur_io && io_buffer_full) begin
                        mem_wr_reg <= 1'b0;
                        state      <= ST_IO_WAIT;
                    end else begin
                        mem_a    <= seq_addr_c;
                        mem_dout <= seq_byte_c;
                    end
                end
                ST_IO_WAIT: begin
                    if (!io_buffer_full) begin
                        mem_a      <= seq_addr_c;
                        mem_dout   <= seq_byte_c;
                        mem_wr_reg <= 1'b1;
                        state      <= ST_WRITE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
